// File: rtl/star_if.sv
// star_if: bus bundle between one STAR softmax tile controller and its helpers
// (input memory, CAM-subtract array, CAM/EXP array and exponent LUT).
//   master : the controller (drives requests, address, xi and match vectors)
//   slave  : the memory / CAM / LUT side (returns data, match vectors, LUT results)
interface star_if #(
    parameter int unsigned LUT_len = 64
);
    logic [7:0]         data;
    logic               data_req;
    logic [8:0]         data_addr;
    logic               CAMSUB_req;
    logic [7:0]         xi;
    logic [LUT_len-1:0] i_xi_MV;
    logic [LUT_len-1:0] o_xmax_MV;
    logic [LUT_len-1:0] o_xi_MV;
    logic               FindSub_req;
    logic               EXP_req;
    logic [LUT_len-1:0] i_sub_MV;
    logic [LUT_len-1:0] o_sub_MV;
    logic [31:0]        exp;
    logic [31:0]        Sum_exp;
    logic               finish;

    modport master (
        input  data, i_xi_MV, i_sub_MV, exp, Sum_exp,
        output data_req, data_addr, CAMSUB_req, xi, o_xmax_MV, o_xi_MV,
               FindSub_req, EXP_req, o_sub_MV, finish
    );

    modport slave (
        output data, i_xi_MV, i_sub_MV, exp, Sum_exp,
        input  data_req, data_addr, CAMSUB_req, xi, o_xmax_MV, o_xi_MV,
               FindSub_req, EXP_req, o_sub_MV, finish
    );
endinterface

// File: rtl/star.sv
// star: softmax datapath controller for one STAR accelerator tile.
// Streams rows of signed 8-bit samples from input memory, then sequences the
// CAM-subtract, FindSub and EXP phases per row, tracking the row maximum as a
// one-hot match vector and forwarding difference vectors to the LUT.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   bus   : star_if master side (requests, address, xi, match vectors, finish)
// All bus outputs are registered.
module star #(
    parameter int unsigned Input_len = 16,
    parameter int unsigned LUT_len   = 64,
    parameter int unsigned N_INPUT   = (Input_len == 16) ? Input_len * Input_len
                                                         : Input_len * Input_len * Input_len
) (
    input  logic   clk,
    input  logic   reset,
    star_if.master bus
);
    localparam int unsigned NRows = N_INPUT / Input_len;
    localparam int unsigned KW    = (Input_len > 2) ? $clog2(Input_len) : 1;
    localparam int unsigned RW    = $clog2(NRows + 1);
    localparam logic [KW-1:0] KLast = KW'(Input_len - 1);
    localparam logic [RW-1:0] RLast = RW'(NRows - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StCamsub, StFindsub, StExp, StDrain, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [RW-1:0]      r_q, r_d;
    logic [7:0]         buf_q [Input_len];
    logic [7:0]         buf_d [Input_len];

    logic               data_req_q, data_req_d;
    logic               camsub_req_q, camsub_req_d;
    logic               findsub_req_q, findsub_req_d;
    logic               exp_req_q, exp_req_d;
    logic               finish_q, finish_d;
    logic [8:0]         data_addr_q, data_addr_d;
    logic [7:0]         xi_q, xi_d;
    logic [LUT_len-1:0] xi_mv_q, xi_mv_d;
    logic [LUT_len-1:0] xmax_q, xmax_d;
    logic [LUT_len-1:0] sub_q, sub_d;

    // LUT results are part of the bus contract but not consumed here.
    logic unused_lut;
    assign unused_lut = ^{bus.exp, bus.Sum_exp};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        buf_d   = buf_q;
        xi_mv_d = xi_mv_q;
        xmax_d  = xmax_q;
        sub_d   = sub_q;

        unique case (state_q)
            StIdle: begin
                state_d = StLoad;
                k_d     = '0;
                r_d     = '0;
            end
            StLoad: begin
                buf_d[k_q] = bus.data;
                if (k_q == KLast) begin
                    state_d = StCamsub;
                    k_d     = '0;
                    xmax_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StCamsub: begin
                xi_mv_d = bus.i_xi_MV;
                // One-hot vectors order the same way as their bit positions.
                if (bus.i_xi_MV > xmax_q) begin
                    xmax_d = bus.i_xi_MV;
                end
                if (k_q == KLast) begin
                    state_d = StFindsub;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StFindsub: begin
                if (k_q == KLast) begin
                    state_d = StExp;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StExp: begin
                sub_d = bus.i_sub_MV;
                if (k_q == KLast) begin
                    state_d = StDrain;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                // First drain cycle keeps the last vector visible, second shows 0.
                if (k_q == '0) begin
                    sub_d = '0;
                    k_d   = KW'(1);
                end else begin
                    k_d     = '0;
                    r_d     = r_q + 1'b1;
                    state_d = (r_q == RLast) ? StDone : StLoad;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        data_req_d    = (state_d == StLoad);
        camsub_req_d  = (state_d == StCamsub);
        findsub_req_d = (state_d == StFindsub);
        exp_req_d     = (state_d == StExp);
        finish_d      = (state_d == StDone);
        data_addr_d   = data_addr_q;
        if (state_d == StLoad) begin
            data_addr_d = 9'(r_d) * 9'(Input_len) + 9'(k_d);
        end
        xi_d = (state_d == StCamsub) ? buf_q[k_d] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            k_q           <= '0;
            r_q           <= '0;
            buf_q         <= '{default: '0};
            data_req_q    <= 1'b0;
            camsub_req_q  <= 1'b0;
            findsub_req_q <= 1'b0;
            exp_req_q     <= 1'b0;
            finish_q      <= 1'b0;
            data_addr_q   <= '0;
            xi_q          <= '0;
            xi_mv_q       <= '0;
            xmax_q        <= '0;
            sub_q         <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            r_q           <= r_d;
            buf_q         <= buf_d;
            data_req_q    <= data_req_d;
            camsub_req_q  <= camsub_req_d;
            findsub_req_q <= findsub_req_d;
            exp_req_q     <= exp_req_d;
            finish_q      <= finish_d;
            data_addr_q   <= data_addr_d;
            xi_q          <= xi_d;
            xi_mv_q       <= xi_mv_d;
            xmax_q        <= xmax_d;
            sub_q         <= sub_d;
        end
    end

    assign bus.data_req    = data_req_q;
    assign bus.data_addr   = data_addr_q;
    assign bus.CAMSUB_req  = camsub_req_q;
    assign bus.xi          = xi_q;
    assign bus.o_xi_MV     = xi_mv_q;
    assign bus.o_xmax_MV   = xmax_q;
    assign bus.FindSub_req = findsub_req_q;
    assign bus.EXP_req     = exp_req_q;
    assign bus.o_sub_MV    = sub_q;
    assign bus.finish      = finish_q;
endmodule

// File: tb/tb_star.sv
// tb_star: self-checking bench for star (Input_len=16, LUT_len=64).
// A cycle-indexed reference model derives every expected output from the row
// data and the phase arithmetic of a 66-cycle row; helper responses are driven
// from the same model, with random junk outside their phases.
module tb_star;
    localparam int L  = 16;
    localparam int NR = 16;
    localparam int NI = 256;
    localparam int RL = 4 * L + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    star_if #(.LUT_len(64)) bus ();

    star #(
        .Input_len(L),
        .LUT_len  (64),
        .N_INPUT  (NI)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic signed [7:0] mem  [NI];
    logic [63:0]       subv [NI];

    typedef struct packed {
        logic        req_d;
        logic        req_c;
        logic        req_f;
        logic        req_e;
        logic        fin;
        logic [8:0]  addr;
        logic [7:0]  xi;
        logic [63:0] xi_mv;
        logic [63:0] xmax_mv;
        logic [63:0] sub_mv;
    } exp_t;

    function automatic logic [63:0] oh(input logic signed [7:0] x);
        logic [63:0] one;
        one = 64'd1;
        return one << (int'(x) + 20);
    endfunction

    function automatic logic signed [7:0] rowmax(input int base, input int cnt);
        logic signed [7:0] m;
        m = mem[base];
        for (int i = 1; i < cnt; i++) begin
            if (mem[base + i] > m) m = mem[base + i];
        end
        return m;
    endfunction

    // Expected outputs after rising edge n following reset release.
    function automatic exp_t model(input int n);
        exp_t e;
        int   p;
        int   row;
        int   c;
        int   k;
        int   base;
        e = '0;
        if (n <= 0) return e;
        p   = n - 1;
        row = p / RL;
        c   = p % RL;
        if (row >= NR) begin
            e.fin     = 1'b1;
            e.addr    = 9'(NI - 1);
            e.xi_mv   = oh(mem[NI - 1]);
            e.xmax_mv = oh(rowmax((NR - 1) * L, L));
            return e;
        end
        base = row * L;
        if (row > 0) begin
            e.addr    = 9'(base - 1);
            e.xi_mv   = oh(mem[base - 1]);
            e.xmax_mv = oh(rowmax(base - L, L));
        end
        if (c < L) begin
            e.req_d = 1'b1;
            e.addr  = 9'(base + c);
        end else if (c < 2 * L) begin
            k       = c - L;
            e.req_c = 1'b1;
            e.xi    = mem[base + k];
            e.addr  = 9'(base + L - 1);
            e.xmax_mv = '0;
            if (k > 0) begin
                e.xi_mv   = oh(mem[base + k - 1]);
                e.xmax_mv = oh(rowmax(base, k));
            end
        end else begin
            e.addr    = 9'(base + L - 1);
            e.xi_mv   = oh(mem[base + L - 1]);
            e.xmax_mv = oh(rowmax(base, L));
            if (c < 3 * L) begin
                e.req_f = 1'b1;
            end else if (c < 4 * L) begin
                k       = c - 3 * L;
                e.req_e = 1'b1;
                if (k > 0) e.sub_mv = subv[base + k - 1];
            end else if (c == 4 * L) begin
                e.sub_mv = subv[base + L - 1];
            end
        end
        return e;
    endfunction

    task automatic init_model(input bit special);
        logic [63:0] one;
        int v;
        one = 64'd1;
        for (int i = 0; i < NI; i++) begin
            v       = int'($urandom_range(63, 0)) - 20;
            mem[i]  = 8'(v);
            subv[i] = one << $urandom_range(63, 0);
        end
        if (special) begin
            mem[0]  = 8'sd0;
            mem[1]  = 8'sd5;
            mem[2]  = -8'sd3;
            mem[3]  = 8'sd43;
            subv[0] = one << 50;
            subv[1] = one << 45;
            for (int i = 32; i < 48; i++) mem[i] = -8'sd20;
        end
    endtask

    // Helper responses for cycle position p (valid from this falling edge).
    task automatic drive(input int p);
        int row;
        int c;
        bus.data     = 8'($urandom);
        bus.i_xi_MV  = {$urandom, $urandom};
        bus.i_sub_MV = {$urandom, $urandom};
        bus.exp      = $urandom;
        bus.Sum_exp  = $urandom;
        if (p >= 0 && p < NR * RL) begin
            row = p / RL;
            c   = p % RL;
            if (c < L) bus.data = mem[row * L + c];
            else if (c < 2 * L) bus.i_xi_MV = oh(mem[row * L + c - L]);
            else if (c >= 3 * L && c < 4 * L) bus.i_sub_MV = subv[row * L + c - 3 * L];
        end
    endtask

    task automatic chk(input string tag, input int n, input logic [63:0] obs,
                       input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s at edge %0d: got %h, expected %h", tag, n, obs, expv);
        end
    endtask

    task automatic check_all(input int n);
        exp_t e;
        e = model(n);
        chk("data_req",    n, 64'(bus.data_req),    64'(e.req_d));
        chk("CAMSUB_req",  n, 64'(bus.CAMSUB_req),  64'(e.req_c));
        chk("FindSub_req", n, 64'(bus.FindSub_req), 64'(e.req_f));
        chk("EXP_req",     n, 64'(bus.EXP_req),     64'(e.req_e));
        chk("finish",      n, 64'(bus.finish),      64'(e.fin));
        chk("data_addr",   n, 64'(bus.data_addr),   64'(e.addr));
        chk("xi",          n, 64'(bus.xi),          64'(e.xi));
        chk("o_xi_MV",     n, bus.o_xi_MV,          e.xi_mv);
        chk("o_xmax_MV",   n, bus.o_xmax_MV,        e.xmax_mv);
        chk("o_sub_MV",    n, bus.o_sub_MV,         e.sub_mv);
    endtask

    task automatic run(input int n_from, input int n_to);
        for (int n = n_from; n <= n_to; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(n);
            drive(n - 1);
        end
    endtask

    initial begin
        // Run 1: full pass with directed rows.
        init_model(1'b1);
        drive(-1);
        repeat (2) @(negedge clk);
        check_all(0);
        reset = 1'b0;
        run(1, 1);
        chk("first_req",  1, 64'(bus.data_req), 64'd1);
        chk("first_addr", 1, 64'(bus.data_addr), 64'd0);
        run(2, 21);
        chk("xmax_after_43", 21, bus.o_xmax_MV, 64'h8000_0000_0000_0000);
        run(22, 51);
        chk("sub_fwd_45", 51, bus.o_sub_MV, 64'h0000_2000_0000_0000);
        run(52, 66);
        chk("sub_drain_zero", 66, bus.o_sub_MV, 64'd0);
        run(67, 67);
        chk("row1_addr", 67, 64'(bus.data_addr), 64'd16);
        run(68, 165);
        chk("xmax_all_min", 165, bus.o_xmax_MV, 64'd1);
        run(166, 1056);
        chk("finish_early", 1056, 64'(bus.finish), 64'd0);
        run(1057, 1057);
        chk("finish_edge", 1057, 64'(bus.finish), 64'd1);
        run(1058, 1065);
        chk("finish_held", 1065, 64'(bus.finish), 64'd1);

        // Run 2: random data, reset during FINDSUB of row 3.
        init_model(1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(1, 239);
        #2 reset = 1'b1;
        #1 check_all(0);
        @(posedge clk);
        @(negedge clk);
        check_all(0);
        drive(-1);
        reset = 1'b0;

        // Run 3: restart after the abort.
        run(1, 1);
        chk("restart_addr", 1, 64'(bus.data_addr), 64'd0);
        run(2, 140);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
